window_buffer_kxk: RTL and testbench
====================================

# window_buffer_kxk

Parametrised sliding-window generator for the streaming edge-detection pipeline. It sits between any pixel-stream stage and a K×K neighbourhood operator, such as the Gaussian-to-Sobel or Sobel-to-NMS boundaries. It accepts one raster-order pixel per enabled cycle and stores 2R image rows. It emits a full (2R+1)×(2R+1) window, with its centre coordinates, for every interior pixel. Frame tracking and resync are built in, so the block re-arms itself for every frame without external control.

## Interface
- DATA_W, 8, pixel width in bits
- IMAGE_WIDTH, 508, pixels per row (≥ 2R+1)
- IMAGE_HEIGHT, 508, rows per frame (≥ 2R+1)
- R, 1, window radius; K = 2R+1 taps per side
- clk  in  1  pipeline clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  in_data is a pixel this cycle (gaps allowed, no backpressure)
- in_sof  in  1  qualified by in_valid: this pixel is (row 0, col 0) of a new frame
- in_data  in  DATA_W  pixel, raster order
- out_valid  out  1  window/coordinates valid this cycle
- out_window  out  K*K*DATA_W  tap t = i*K+j at [t*DATA_W +: DATA_W]; i = 0 is the top (oldest) row, j = 0 is the leftmost (oldest) column
- out_row  out  clog2(IMAGE_HEIGHT)  row of the window centre tap
- out_col  out  clog2(IMAGE_WIDTH)  column of the window centre tap
- frame_done  out  1  one-cycle pulse coincident with the last window of a frame

## Operation
- Input position counters: col_in in 0..IMAGE_WIDTH-1 and row_in in 0..IMAGE_HEIGHT-1. They advance only on in_valid. col_in wraps to 0 and increments row_in; row_in wraps to 0 after the last pixel of the frame.
- When in_valid is high and in_sof is high, the current pixel is treated as (0,0) regardless of counter state. Counters then continue from (0,1). The partial previous frame is abandoned and no frame_done is issued for it.
- Storage is 2R chained row delays, each IMAGE_WIDTH deep, plus a K×K register array. On in_valid:
  - each window row shifts left by one column;
  - column K-1 of window row i is loaded from the row-delay tap for row (row_in − (K−1−i));
  - row K-1 is loaded from in_data.
- Row-delay and window contents are never reset. Validity is derived only from the counters.
- out_valid is registered: it is high in the cycle after accepting pixel (r,c) iff r ≥ 2R and c ≥ 2R. For that window, out_row = r−R and out_col = c−R.
- Border windows are never emitted. Each frame produces exactly (IMAGE_WIDTH−2R)·(IMAGE_HEIGHT−2R) windows.
- frame_done is high together with out_valid for the window accepted at (IMAGE_HEIGHT−1, IMAGE_WIDTH−1).
- When in_valid is low:
  - no storage moves and the counters hold;
  - out_valid and frame_done are 0 the following cycle;
  - out_window, out_row and out_col hold their last values.

## Timing
- Latency: 1 cycle from the accepting edge to out_valid.
- Sustained throughput: one window per cycle with in_valid held high.
- Reset values:
  - out_valid = 0, frame_done = 0, out_row = 0, out_col = 0, out_window = 0;
  - col_in = 0, row_in = 0.
- Reset asserted mid-frame: on the next edge the counters return to (0,0) and outputs go to their reset values. The first pixel after reset is (0,0) whether or not in_sof is set.
- in_sof together with rst: rst wins.
- in_sof without in_valid is ignored.
- Wrap at end of frame: the next accepted pixel is (0,0) of the next frame. The first window of that frame appears only after 2R new rows plus 2R pixels have been accepted. Stale rows are never emitted.

## Structure
- Shared package window_pkg holds:
  - localparam helpers K(R) and TAP(i,j) = i*K+j;
  - a centre-tap index function;
  - counter-width helpers based on clog2.
- Sub-module line_delay: an enable-gated, IMAGE_WIDTH-deep, DATA_W-wide delay line. It is instantiated 2R times and is inferable as BRAM or SRL.
- Top level contains the counters, the validity and coordinate logic, and the K×K register array.

## Test plan
- IMAGE_WIDTH=6, IMAGE_HEIGHT=5, R=1, pixel = row*16+col, in_valid held high:
  - first out_valid follows pixel 0x22, with out_row=1, out_col=1;
  - taps are 0x00,0x01,0x02,0x10,0x11,0x12,0x20,0x21,0x22;
  - exactly 12 windows are emitted;
  - frame_done comes with the window centred at (3,4).
- Same frame with random in_valid gaps: the window sequence is identical to the gap-free run, and out_valid is never high in the cycle after in_valid was low.
- Two back-to-back frames with in_sof on each first pixel: 12 windows per frame, 2 frame_done pulses, and the second frame contains no window mixing rows from frame 1.
- in_sof asserted at pixel (2,3) of frame 1:
  - counters restart;
  - no frame_done is issued for frame 1;
  - the next out_valid is at the new (2,2), with centre coordinates (1,1).
- rst pulsed mid-frame after 20 pixels: outputs are 0 the next cycle, and a fresh frame then yields 12 correct windows.
- R=2, IMAGE_WIDTH=7, IMAGE_HEIGHT=6:
  - first window has centre (2,2) and tap 0 = pixel 0x00;
  - 3·2 = 6 windows are emitted;
  - centre tap = pixel at (out_row, out_col).

Source files
------------

// File: rtl/window_pkg.sv
// Shared helpers for the K x K sliding-window generator: window geometry,
// tap indexing and counter widths.
package window_pkg;

  function automatic int k_of(input int r);
    return 2 * r + 1;
  endfunction

  // Flat tap index; row 0 is the oldest row, column 0 the oldest column.
  function automatic int tap(input int i, input int j, input int k);
    return i * k + j;
  endfunction

  function automatic int centre_tap(input int r);
    return tap(r, r, k_of(r));
  endfunction

  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/window_buffer_kxk_line_delay.sv
// Enable-gated fixed-depth delay line built as a circular buffer so that it
// maps onto block or distributed RAM (read-before-write on one address).
module line_delay
  import window_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 508
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_en,
  input  logic [DATA_W-1:0] i_data,
  output logic [DATA_W-1:0] o_data
);

  localparam int AW = cnt_w(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_ptr;

  assign o_data = r_mem[r_ptr];

  // Storage is deliberately not reset; stale contents are masked by the
  // validity counters in the parent.
  always_ff @(posedge clk) begin
    if (i_en) begin
      r_mem[r_ptr] <= i_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (i_en) begin
      r_ptr <= (r_ptr == AW'(DEPTH - 1)) ? '0 : r_ptr + AW'(1);
    end
  end

endmodule

// File: rtl/window_buffer_kxk.sv
// Streaming (2R+1)x(2R+1) window generator: 2R row delays feed a K x K
// register array; raster counters gate validity and give centre coordinates.
module window_buffer_kxk
  import window_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int IMAGE_WIDTH  = 508,
  parameter int IMAGE_HEIGHT = 508,
  parameter int R            = 1
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   in_valid,
  input  logic                                   in_sof,
  input  logic [DATA_W-1:0]                      in_data,
  output logic                                   out_valid,
  output logic [k_of(R)*k_of(R)*DATA_W-1:0]      out_window,
  output logic [cnt_w(IMAGE_HEIGHT)-1:0]         out_row,
  output logic [cnt_w(IMAGE_WIDTH)-1:0]          out_col,
  output logic                                   frame_done
);

  localparam int K  = k_of(R);
  localparam int ND = 2 * R;
  localparam int CW = cnt_w(IMAGE_WIDTH);
  localparam int RW = cnt_w(IMAGE_HEIGHT);

  logic [CW-1:0] r_col_in;
  logic [RW-1:0] r_row_in;
  logic [CW-1:0] w_col;
  logic [RW-1:0] w_row;
  logic [CW-1:0] w_col_nxt;
  logic [RW-1:0] w_row_nxt;
  logic          w_last_col;
  logic          w_last_row;
  logic          w_interior;

  // w_tap[0] is the live pixel; w_tap[n] is the same column n rows earlier.
  logic [ND:0][DATA_W-1:0]   w_tap;
  logic [DATA_W-1:0]         r_win      [K][K];
  logic [DATA_W-1:0]         w_win_next [K][K];
  logic [K*K*DATA_W-1:0]     w_win_flat;

  logic                      r_out_valid;
  logic                      r_frame_done;
  logic [RW-1:0]             r_out_row;
  logic [CW-1:0]             r_out_col;
  logic [K*K*DATA_W-1:0]     r_out_window;

  assign w_tap[0] = in_data;

  for (genvar n = 0; n < ND; n++) begin : g_rows
    line_delay #(
      .DATA_W (DATA_W),
      .DEPTH  (IMAGE_WIDTH)
    ) u_line_delay (
      .clk    (clk),
      .rst    (rst),
      .i_en   (in_valid),
      .i_data (w_tap[n]),
      .o_data (w_tap[n+1])
    );
  end

  // Position of the pixel offered this cycle; sof forces (0,0).
  always_comb begin
    w_col      = in_sof ? '0 : r_col_in;
    w_row      = in_sof ? '0 : r_row_in;
    w_last_col = (w_col == CW'(IMAGE_WIDTH - 1));
    w_last_row = (w_row == RW'(IMAGE_HEIGHT - 1));
    w_interior = (w_row >= RW'(ND)) && (w_col >= CW'(ND));
    w_col_nxt  = w_col + CW'(1);
    w_row_nxt  = w_row;
    if (w_last_col) begin
      w_col_nxt = '0;
      if (w_last_row) begin
        w_row_nxt = '0;
      end else begin
        w_row_nxt = w_row + RW'(1);
      end
    end else begin
      w_col_nxt = w_col + CW'(1);
    end
  end

  // Window shifted by one column with the new column entering at K-1.
  always_comb begin
    w_win_flat = '0;
    for (int i = 0; i < K; i++) begin
      for (int j = 0; j < K - 1; j++) begin
        w_win_next[i][j] = r_win[i][j+1];
      end
      w_win_next[i][K-1] = w_tap[K-1-i];
    end
    for (int i = 0; i < K; i++) begin
      for (int j = 0; j < K; j++) begin
        w_win_flat[tap(i, j, K)*DATA_W +: DATA_W] = w_win_next[i][j];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (in_valid) begin
      r_win <= w_win_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_col_in     <= '0;
      r_row_in     <= '0;
      r_out_valid  <= 1'b0;
      r_frame_done <= 1'b0;
      r_out_row    <= '0;
      r_out_col    <= '0;
      r_out_window <= '0;
    end else if (in_valid) begin
      r_col_in     <= w_col_nxt;
      r_row_in     <= w_row_nxt;
      r_out_valid  <= w_interior;
      r_frame_done <= w_last_row && w_last_col;
      r_out_window <= w_win_flat;
      // Coordinates only move for emitted windows, so border pixels never
      // expose an underflowed centre.
      if (w_interior) begin
        r_out_row <= w_row - RW'(R);
        r_out_col <= w_col - CW'(R);
      end
    end else begin
      r_out_valid  <= 1'b0;
      r_frame_done <= 1'b0;
    end
  end

  assign out_valid  = r_out_valid;
  assign frame_done = r_frame_done;
  assign out_row    = r_out_row;
  assign out_col    = r_out_col;
  assign out_window = r_out_window;

endmodule

// File: tb/tb_window_buffer_kxk.sv
// Directed bench: a 6x5 R=1 instance and a 7x6 R=2 instance, pixel value
// base + row*16 + col, expected windows rebuilt from the driven coordinates.
module tb_window_buffer_kxk;
  import window_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        v1, s1, ov1, fd1;
  logic [7:0]  d1;
  logic [71:0] w1;
  logic [2:0]  or1, oc1;
  logic        v2, s2, ov2, fd2;
  logic [7:0]  d2;
  logic [199:0] w2;
  logic [2:0]  or2, oc2;

  int checks = 0;
  int errors = 0;
  int nwin   = 0;
  int nfd    = 0;

  window_buffer_kxk #(.DATA_W(8), .IMAGE_WIDTH(6), .IMAGE_HEIGHT(5), .R(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(v1), .in_sof(s1), .in_data(d1),
    .out_valid(ov1), .out_window(w1), .out_row(or1), .out_col(oc1), .frame_done(fd1)
  );

  window_buffer_kxk #(.DATA_W(8), .IMAGE_WIDTH(7), .IMAGE_HEIGHT(6), .R(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(v2), .in_sof(s2), .in_data(d2),
    .out_valid(ov2), .out_window(w2), .out_row(or2), .out_col(oc2), .frame_done(fd2)
  );

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Window after accepting (r,c): tap(i,j) is pixel (r-(k-1)+i, c-(k-1)+j).
  function automatic logic [255:0] exp_win(input int k, input int r, input int c,
                                           input logic [7:0] base);
    logic [255:0] w;
    w = '0;
    for (int i = 0; i < k; i++) begin
      for (int j = 0; j < k; j++) begin
        w[(i*k+j)*8 +: 8] = base + 8'((r - (k-1) + i) * 16 + (c - (k-1) + j));
      end
    end
    return w;
  endfunction

  task automatic px1(input logic sof, input int r, input int c, input logic [7:0] base);
    @(negedge clk);
    v1 = 1'b1; s1 = sof; d1 = base + 8'(r * 16 + c);
    @(posedge clk); #1;
    if (ov1) nwin++;
    if (fd1) nfd++;
    chk("valid1", 256'(ov1), 256'(r >= 2 && c >= 2));
    chk("fdone1", 256'(fd1), 256'(r == 4 && c == 5));
    if (r >= 2 && c >= 2) begin
      chk("row1", 256'(or1), 256'(r - 1));
      chk("col1", 256'(oc1), 256'(c - 1));
      chk("win1", 256'(w1), exp_win(3, r, c, base));
    end
  endtask

  task automatic idle1(input logic sof);
    @(negedge clk);
    v1 = 1'b0; s1 = sof; d1 = 8'hEE;
    @(posedge clk); #1;
    chk("idle_valid1", 256'(ov1), 256'(0));
    chk("idle_fdone1", 256'(fd1), 256'(0));
  endtask

  task automatic frame1(input logic first_sof, input logic gaps, input logic [7:0] base);
    for (int r = 0; r < 5; r++) begin
      for (int c = 0; c < 6; c++) begin
        if (gaps) begin
          for (int g = 0; g < (r * 6 + c) % 3; g++) idle1(1'(c % 2));
        end
        px1((r == 0 && c == 0) ? first_sof : 1'b0, r, c, base);
      end
    end
  endtask

  task automatic px2(input int r, input int c);
    @(negedge clk);
    v2 = 1'b1; s2 = (r == 0 && c == 0); d2 = 8'(r * 16 + c);
    @(posedge clk); #1;
    if (ov2) nwin++;
    if (fd2) nfd++;
    chk("valid2", 256'(ov2), 256'(r >= 4 && c >= 4));
    chk("fdone2", 256'(fd2), 256'(r == 5 && c == 6));
    if (r >= 4 && c >= 4) begin
      chk("row2", 256'(or2), 256'(r - 2));
      chk("col2", 256'(oc2), 256'(c - 2));
      chk("tap0_2", 256'(w2[7:0]), 256'((r - 4) * 16 + (c - 4)));
      chk("centre2", 256'(w2[centre_tap(2)*8 +: 8]), 256'((r - 2) * 16 + (c - 2)));
      chk("win2", 256'(w2), exp_win(5, r, c, 8'h00));
    end
  endtask

  initial begin
    rst = 1'b1;
    v1 = 1'b0; s1 = 1'b0; d1 = 8'h00;
    v2 = 1'b0; s2 = 1'b0; d2 = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 256'(ov1), 256'(0));
    chk("rst_fdone", 256'(fd1), 256'(0));
    chk("rst_row", 256'(or1), 256'(0));
    chk("rst_col", 256'(oc1), 256'(0));
    chk("rst_win", 256'(w1), 256'(0));
    chk("rst_win2", 256'(w2), 256'(0));
    @(negedge clk);
    rst = 1'b0;

    // Gap-free frame; first window checked against the hand-built taps.
    nwin = 0; nfd = 0;
    for (int r = 0; r < 5; r++) begin
      for (int c = 0; c < 6; c++) begin
        px1(r == 0 && c == 0, r, c, 8'h00);
        if (r == 2 && c == 2) begin
          chk("first_win", 256'(w1), 256'(72'h222120_121110_020100));
        end
      end
    end
    chk("nwin_a", 256'(nwin), 256'(12));
    chk("nfd_a", 256'(nfd), 256'(1));

    // Same frame with gaps, then a second frame with distinct pixel values.
    nwin = 0; nfd = 0;
    frame1(1'b1, 1'b1, 8'h00);
    frame1(1'b1, 1'b0, 8'h80);
    chk("nwin_bc", 256'(nwin), 256'(24));
    chk("nfd_bc", 256'(nfd), 256'(2));

    // Partial frame abandoned by sof arriving at its pixel (2,3).
    nwin = 0; nfd = 0;
    for (int p = 0; p < 15; p++) px1(p == 0, p / 6, p % 6, 8'h00);
    frame1(1'b1, 1'b0, 8'h80);
    chk("nwin_de", 256'(nwin), 256'(13));
    chk("nfd_de", 256'(nfd), 256'(1));

    // Reset after 20 pixels (rst overrides a concurrent sof), then a fresh frame without sof.
    for (int p = 0; p < 20; p++) px1(p == 0, p / 6, p % 6, 8'h00);
    @(negedge clk);
    rst = 1'b1; v1 = 1'b1; s1 = 1'b1; d1 = 8'hFF;
    @(posedge clk); #1;
    chk("mrst_valid", 256'(ov1), 256'(0));
    chk("mrst_fdone", 256'(fd1), 256'(0));
    chk("mrst_row", 256'(or1), 256'(0));
    chk("mrst_col", 256'(oc1), 256'(0));
    chk("mrst_win", 256'(w1), 256'(0));
    @(negedge clk);
    rst = 1'b0; v1 = 1'b0; s1 = 1'b0;
    nwin = 0; nfd = 0;
    frame1(1'b0, 1'b0, 8'h80);
    chk("nwin_g", 256'(nwin), 256'(12));
    chk("nfd_g", 256'(nfd), 256'(1));
    @(negedge clk);
    v1 = 1'b0;

    // Radius-2 instance over a 7x6 frame.
    nwin = 0; nfd = 0;
    for (int r = 0; r < 6; r++) begin
      for (int c = 0; c < 7; c++) px2(r, c);
    end
    chk("nwin_r2", 256'(nwin), 256'(6));
    chk("nfd_r2", 256'(nfd), 256'(1));
    @(negedge clk);
    v2 = 1'b0;
    @(posedge clk); #1;
    chk("idle_valid2", 256'(ov2), 256'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
